cache_ctrl_wb: RTL and testbench
================================

# cache_ctrl_wb

Parametrised write-back cache controller FSM, successor to the single-word write-through cache controller in the cache datapath. It sits between the CPU request port (`Strobe`/`DRW`) and the tag/data arrays plus main memory, and it drives the array write enables, datapath muxes and memory strobes. Compared with its predecessor it adds:

- multi-word line refill with a word index;
- dirty-line write-back;
- an optional write-allocate mode;
- a fully parametrised memory wait-state count with an internal counter.

## Interface

Parameters:

- `WAIT_CYCLES`, default 4, memory latency in cycles per word access; must be ≥1.
- `LINE_WORDS`, default 4, words per cache line; must be a power of 2, ≥1.
- `WRITE_ALLOC`, default 1: 1 = write miss allocates the line; 0 = write-around (direct memory write).
- `CTR_W`, default 8, wait counter width; must hold `WAIT_CYCLES`.

Ports (`WIDX_W = max(1, $clog2(LINE_WORDS))`):

- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `Strobe` in 1: CPU request valid; sampled only in IDLE.
- `DRW` in 1: 1 = write, 0 = read; sampled with `Strobe`.
- `M` in 1: tag match for the request index.
- `V` in 1: valid bit of the indexed line.
- `D` in 1: dirty bit of the indexed line.
- `DReady` out 1: one-cycle request-complete pulse.
- `W` out 1: data array word write enable.
- `WTag` out 1: write tag, set V=1 and clear dirty for the indexed line.
- `SetDirty` out 1: set dirty bit of the indexed line.
- `MStrobe` out 1: one-cycle memory access start.
- `MRW` out 1: memory direction, 1 = write.
- `MAddrSel` out 1: memory address tag source, 1 = victim (stored) tag, 0 = request tag.
- `WSel` out 1: data array write source, 1 = memory data, 0 = CPU data.
- `RSel` out 1: memory write data source, 1 = CPU data, 0 = cache array word.
- `WordIdx` out `WIDX_W`: line word being transferred.

## Operation

States and transitions:

- IDLE: if `Strobe` is sampled high, go to LOOKUP, registering `DRW`. Otherwise stay.
- LOOKUP: evaluates hit = `M & V`.
  - read hit → DONE.
  - write hit → WR_CPU.
  - miss with allocation (read, or write with `WRITE_ALLOC`=1) → WB_REQ if `V & D`, else FILL_REQ.
  - write miss with `WRITE_ALLOC`=0 → MW_REQ.
- WB_REQ: asserts `MStrobe=1`, `MRW=1`, `MAddrSel=1`, `RSel=0`, `WordIdx`. Loads the wait counter. Goes to WB_WAIT.
- WB_WAIT: holds `MRW=1` and `MAddrSel=1` for `WAIT_CYCLES` cycles. Then:
  - if this is the last word, reset the word index and go to FILL_REQ;
  - else increment the word index and go to WB_REQ.
- FILL_REQ: asserts `MStrobe=1`, `MRW=0`. Loads the counter. Goes to FILL_WAIT.
- FILL_WAIT: lasts `WAIT_CYCLES` cycles, then goes to FILL_WR.
- FILL_WR: asserts `W=1`, `WSel=1`, `WordIdx`. `WTag=1` is asserted on the last word only. Then:
  - last word: DONE for a read; WR_CPU for an allocating write;
  - otherwise increment the index and go to FILL_REQ.
- WR_CPU: asserts `W=1`, `WSel=0`, `SetDirty=1`. Goes to DONE.
- MW_REQ / MW_WAIT: `MStrobe=1`, `MRW=1`, `MAddrSel=0`, `RSel=1` in MW_REQ, then `WAIT_CYCLES` wait cycles with `MRW`/`MAddrSel`/`RSel` held. Then DONE. The cache array is not modified.
- DONE: `DReady=1` for one cycle, then IDLE.

Rules:

- Outputs are a pure function of state and word index (Moore). There is no combinational path from `M`/`V`/`D` to any output.
- `Strobe` is ignored in every state except IDLE. A request held high through DONE is re-accepted in IDLE as a new request.
- `M`, `V` and `D` are sampled only in LOOKUP.
- The word index wraps from `LINE_WORDS-1` to 0.

## Timing

- Reset: all outputs 0, state IDLE, word index 0, counter 0. Reset is immediate and asynchronous, including mid-burst. Any memory access in flight is abandoned; no `DReady` is produced.
- Request sampled at edge 0 → LOOKUP in cycle 1.
- `DReady` cycle, with `P = LINE_WORDS*(WAIT_CYCLES+2)` (fill) and `Q = LINE_WORDS*(WAIT_CYCLES+1)` (write-back):
  - read hit: cycle 2;
  - write hit: cycle 3;
  - clean read miss: 2+P;
  - dirty read miss: 2+Q+P;
  - allocating write miss: 3+P (clean) or 3+Q+P (dirty);
  - write-around miss: 3+`WAIT_CYCLES`.
- `MStrobe` is never high on two consecutive cycles.

## Structure

- `cache_ctrl_pkg` holds:
  - the state enum `cc_state_t` (IDLE, LOOKUP, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, FILL_WR, WR_CPU, MW_REQ, MW_WAIT, DONE);
  - the output-bundle struct.
- One sub-module, `cc_wait_counter`: loadable down-counter of width `CTR_W` with a `done` flag, asynchronous active-low reset.

## Test plan

- Defaults, read with `M=1`, `V=1` → `DReady` pulse at cycle 2; no `MStrobe`, `W`=0 throughout.
- Defaults, read with `V=1`, `D=0`, `M=0` → 4 `MStrobe` pulses with `MRW=0`, 4 `W` pulses at `WordIdx` 0..3 with `WSel=1`, `WTag` on the 4th only, `DReady` at cycle 26.
- Defaults, read with `M=0`, `V=1`, `D=1` → 4 write-back strobes (`MRW=1`, `MAddrSel=1`), then 4 fills; `DReady` at cycle 46.
- Write hit → `W`+`SetDirty` at cycle 2 with `WSel=0`, `DReady` at cycle 3. With `WRITE_ALLOC`=0 and a write miss → single `MStrobe` with `MRW=1`, `RSel=1`, `DReady` at cycle 7, `W` never asserted.
- Parameters `LINE_WORDS=1`, `WAIT_CYCLES=1`, clean read miss → `DReady` at cycle 5.
- `reset` asserted in the third FILL_WAIT cycle → all outputs 0 immediately. After release with `Strobe=0`, the block stays in IDLE and produces no `DReady`.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// Shared types for the write-back cache controller: FSM state encoding,
// the registered control-output bundle and its per-state decode.
package cache_ctrl_pkg;

   typedef enum logic [3:0] {
      IDLE,
      LOOKUP,
      WB_REQ,
      WB_WAIT,
      FILL_REQ,
      FILL_WAIT,
      FILL_WR,
      WR_CPU,
      MW_REQ,
      MW_WAIT,
      DONE
   } cc_state_t;

   // Control outputs driven toward the arrays, datapath muxes and memory.
   typedef struct packed {
      logic dready;
      logic w;
      logic wtag;
      logic set_dirty;
      logic mstrobe;
      logic mrw;
      logic maddr_sel;
      logic wsel;
      logic rsel;
   } cc_out_t;

   // Per-state control decode; wtag depends on the word index and is added by the caller.
   function automatic cc_out_t cc_decode(input cc_state_t s);
      cc_out_t o;
      o = '0;
      case (s)
         WB_REQ: begin
            o.mstrobe   = 1'b1;
            o.mrw       = 1'b1;
            o.maddr_sel = 1'b1;
         end
         WB_WAIT: begin
            o.mrw       = 1'b1;
            o.maddr_sel = 1'b1;
         end
         FILL_REQ:  o.mstrobe = 1'b1;
         FILL_WR: begin
            o.w    = 1'b1;
            o.wsel = 1'b1;
         end
         WR_CPU: begin
            o.w         = 1'b1;
            o.set_dirty = 1'b1;
         end
         MW_REQ: begin
            o.mstrobe = 1'b1;
            o.mrw     = 1'b1;
            o.rsel    = 1'b1;
         end
         MW_WAIT: begin
            o.mrw  = 1'b1;
            o.rsel = 1'b1;
         end
         DONE:      o.dready = 1'b1;
         default:   o = '0;
      endcase
      return o;
   endfunction

   // States in which the line word index is presented on WordIdx.
   function automatic logic cc_uses_widx(input cc_state_t s);
      return (s == WB_REQ) || (s == WB_WAIT) || (s == FILL_REQ) ||
             (s == FILL_WAIT) || (s == FILL_WR);
   endfunction

endpackage

// File: rtl/cc_wait_counter.sv
// Loadable down-counter timing memory wait states.
// Ports: clk, reset (async active-low), load/load_val (preset), en (count down),
// done (registered; high during the last wait cycle of a loaded interval).
module cc_wait_counter #(
   parameter int unsigned CTR_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             en,
   input  logic [CTR_W-1:0] load_val,
   output logic             done
);

   logic [CTR_W-1:0] count;

   // done tracks "count <= 1" so the FSM leaves a wait state after exactly load_val cycles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
         done  <= 1'b0;
      end else if (load) begin
         count <= load_val;
         done  <= (load_val <= CTR_W'(1));
      end else if (en && (count != '0)) begin
         count <= count - CTR_W'(1);
         done  <= (count <= CTR_W'(2));
      end
   end

endmodule

// File: rtl/cache_ctrl_wb.sv
// Write-back cache controller FSM with multi-word refill, dirty write-back,
// optional write-allocate and parametrised memory wait states.
// Ports: clk, reset (async active-low); CPU request Strobe/DRW; lookup status M/V/D;
// registered Moore controls DReady, W, WTag, SetDirty, MStrobe, MRW, MAddrSel,
// WSel, RSel and the transfer word index WordIdx.
module cache_ctrl_wb
   import cache_ctrl_pkg::*;
#(
   parameter  int unsigned WAIT_CYCLES = 4,
   parameter  int unsigned LINE_WORDS  = 4,
   parameter  int unsigned WRITE_ALLOC = 1,
   parameter  int unsigned CTR_W       = 8,
   localparam int unsigned WIDX_W      = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              Strobe,
   input  logic              DRW,
   input  logic              M,
   input  logic              V,
   input  logic              D,
   output logic              DReady,
   output logic              W,
   output logic              WTag,
   output logic              SetDirty,
   output logic              MStrobe,
   output logic              MRW,
   output logic              MAddrSel,
   output logic              WSel,
   output logic              RSel,
   output logic [WIDX_W-1:0] WordIdx
);

   localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(LINE_WORDS - 1);

   cc_state_t         state, state_n;
   logic [WIDX_W-1:0] widx, widx_n;
   logic              drw_q, drw_n;
   cc_out_t           out_q, out_n;
   logic [WIDX_W-1:0] widx_out_q, widx_out_n;
   logic              is_last;
   logic              ctr_load, ctr_en, ctr_done;

   assign is_last  = (widx == LAST_IDX);
   assign ctr_load = (state == WB_REQ) || (state == FILL_REQ) || (state == MW_REQ);
   assign ctr_en   = (state == WB_WAIT) || (state == FILL_WAIT) || (state == MW_WAIT);

   // Memory wait-state timer.
   cc_wait_counter #(
      .CTR_W(CTR_W)
   ) u_wait (
      .clk      (clk),
      .reset    (reset),
      .load     (ctr_load),
      .en       (ctr_en),
      .load_val (CTR_W'(WAIT_CYCLES)),
      .done     (ctr_done)
   );

   // State, word index, latched direction and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         widx       <= '0;
         drw_q      <= 1'b0;
         out_q      <= '0;
         widx_out_q <= '0;
      end else begin
         state      <= state_n;
         widx       <= widx_n;
         drw_q      <= drw_n;
         out_q      <= out_n;
         widx_out_q <= widx_out_n;
      end
   end

   // Next state, word index and request direction.
   always_comb begin
      state_n = state;
      widx_n  = widx;
      drw_n   = drw_q;
      case (state)
         IDLE: begin
            if (Strobe) begin
               state_n = LOOKUP;
               drw_n   = DRW;
            end
         end
         LOOKUP: begin
            widx_n = '0;
            if (M && V)                            state_n = drw_q ? WR_CPU : DONE;
            else if (drw_q && (WRITE_ALLOC == 0))  state_n = MW_REQ;
            else if (V && D)                       state_n = WB_REQ;
            else                                   state_n = FILL_REQ;
         end
         WB_REQ:    state_n = WB_WAIT;
         WB_WAIT: begin
            if (ctr_done) begin
               if (is_last) begin
                  widx_n  = '0;
                  state_n = FILL_REQ;
               end else begin
                  widx_n  = widx + WIDX_W'(1);
                  state_n = WB_REQ;
               end
            end
         end
         FILL_REQ:  state_n = FILL_WAIT;
         FILL_WAIT: if (ctr_done) state_n = FILL_WR;
         FILL_WR: begin
            if (is_last) begin
               widx_n  = '0;
               state_n = drw_q ? WR_CPU : DONE;
            end else begin
               widx_n  = widx + WIDX_W'(1);
               state_n = FILL_REQ;
            end
         end
         WR_CPU:    state_n = DONE;
         MW_REQ:    state_n = MW_WAIT;
         MW_WAIT:   if (ctr_done) state_n = DONE;
         DONE:      state_n = IDLE;
         default:   state_n = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the registered copy equals decode(state).
   always_comb begin
      out_n      = cc_decode(state_n);
      out_n.wtag = (state_n == FILL_WR) && (widx_n == LAST_IDX);
      widx_out_n = cc_uses_widx(state_n) ? widx_n : '0;
   end

   assign DReady   = out_q.dready;
   assign W        = out_q.w;
   assign WTag     = out_q.wtag;
   assign SetDirty = out_q.set_dirty;
   assign MStrobe  = out_q.mstrobe;
   assign MRW      = out_q.mrw;
   assign MAddrSel = out_q.maddr_sel;
   assign WSel     = out_q.wsel;
   assign RSel     = out_q.rsel;
   assign WordIdx  = widx_out_q;

endmodule

// File: tb/tb_cache_ctrl_wb.sv
// Scoreboard bench for cache_ctrl_wb: three instances (defaults, write-around,
// single-word line with one wait state) with per-instance expected-event queues.
module tb_cache_ctrl_wb;

   typedef struct packed {
      logic [15:0] cyc;
      logic [8:0]  fl;
      logic [3:0]  idx;
   } ev_t;

   localparam logic [8:0] F_DREADY = 9'h100;
   localparam logic [8:0] F_W      = 9'h080;
   localparam logic [8:0] F_WTAG   = 9'h040;
   localparam logic [8:0] F_SETD   = 9'h020;
   localparam logic [8:0] F_MSTB   = 9'h010;
   localparam logic [8:0] F_MRW    = 9'h008;
   localparam logic [8:0] F_MAS    = 9'h004;
   localparam logic [8:0] F_WSEL   = 9'h002;
   localparam logic [8:0] F_RSEL   = 9'h001;

   logic clk, reset;
   int   cyc;
   int   checks, passes;
   int   t0 [3];
   logic prev_mstb [3];
   ev_t  q_a[$], q_b[$], q_c[$];

   logic strobe_a, drw_a, m_a, v_a, d_a;
   logic strobe_b, drw_b, m_b, v_b, d_b;
   logic strobe_c, drw_c, m_c, v_c, d_c;
   logic dready_a, w_a, wtag_a, setd_a, mstb_a, mrw_a, mas_a, wsel_a, rsel_a;
   logic dready_b, w_b, wtag_b, setd_b, mstb_b, mrw_b, mas_b, wsel_b, rsel_b;
   logic dready_c, w_c, wtag_c, setd_c, mstb_c, mrw_c, mas_c, wsel_c, rsel_c;
   logic [1:0] widx_a, widx_b;
   logic [0:0] widx_c;

   cache_ctrl_wb u_a (
      .clk(clk), .reset(reset), .Strobe(strobe_a), .DRW(drw_a), .M(m_a), .V(v_a), .D(d_a),
      .DReady(dready_a), .W(w_a), .WTag(wtag_a), .SetDirty(setd_a), .MStrobe(mstb_a),
      .MRW(mrw_a), .MAddrSel(mas_a), .WSel(wsel_a), .RSel(rsel_a), .WordIdx(widx_a));

   cache_ctrl_wb #(.WRITE_ALLOC(0)) u_b (
      .clk(clk), .reset(reset), .Strobe(strobe_b), .DRW(drw_b), .M(m_b), .V(v_b), .D(d_b),
      .DReady(dready_b), .W(w_b), .WTag(wtag_b), .SetDirty(setd_b), .MStrobe(mstb_b),
      .MRW(mrw_b), .MAddrSel(mas_b), .WSel(wsel_b), .RSel(rsel_b), .WordIdx(widx_b));

   cache_ctrl_wb #(.LINE_WORDS(1), .WAIT_CYCLES(1)) u_c (
      .clk(clk), .reset(reset), .Strobe(strobe_c), .DRW(drw_c), .M(m_c), .V(v_c), .D(d_c),
      .DReady(dready_c), .W(w_c), .WTag(wtag_c), .SetDirty(setd_c), .MStrobe(mstb_c),
      .MRW(mrw_c), .MAddrSel(mas_c), .WSel(wsel_c), .RSel(rsel_c), .WordIdx(widx_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic ev_t mk(input int c, input logic [8:0] f, input int i);
      ev_t e;
      e.cyc = 16'(c);
      e.fl  = f;
      e.idx = 4'(i);
      return e;
   endfunction

   function automatic void push_a(input int c, input logic [8:0] f, input int i);
      q_a.push_back(mk(c, f, i));
   endfunction

   // Refill of words 0..n-1 starting with FILL_REQ at cycle base (6 cycles per word).
   function automatic void push_fill_a(input int base, input int n);
      for (int i = 0; i < n; i++) begin
         push_a(base + 6*i, F_MSTB, i);
         push_a(base + 6*i + 5, F_W | F_WSEL | ((i == 3) ? F_WTAG : 9'h000), i);
      end
   endfunction

   // Write-back of 4 words starting with WB_REQ at cycle base (5 cycles per word).
   function automatic void push_wb_a(input int base);
      for (int i = 0; i < 4; i++) push_a(base + 5*i, F_MSTB | F_MRW | F_MAS, i);
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   // Scoreboard monitor body: pops the next expected event whenever the DUT shows one.
   task automatic observe(input int k, input logic [8:0] fl, input int idx);
      ev_t a, e;
      logic got;
      int rel;
      rel = cyc - t0[k];
      if (fl[4]) begin
         checks++;
         if (!prev_mstb[k]) passes++;
         else $display("FAIL mstrobe_b2b[%0d]: MStrobe high on consecutive cycles at cycle %0d", k, rel);
      end
      prev_mstb[k] = fl[4];
      if (fl[8] || fl[7] || fl[4]) begin
         a = mk(rel, fl, idx);
         got = 1'b0;
         e = '0;
         case (k)
            0: if (q_a.size() > 0) begin e = q_a.pop_front(); got = 1'b1; end
            1: if (q_b.size() > 0) begin e = q_b.pop_front(); got = 1'b1; end
            default: if (q_c.size() > 0) begin e = q_c.pop_front(); got = 1'b1; end
         endcase
         checks++;
         if (!got)
            $display("FAIL unexpected_event[%0d]: got cyc=%0d flags=%b idx=%0d, expected no event",
                     k, a.cyc, a.fl, a.idx);
         else if (a == e) passes++;
         else
            $display("FAIL event[%0d]: got cyc=%0d flags=%b idx=%0d, expected cyc=%0d flags=%b idx=%0d",
                     k, a.cyc, a.fl, a.idx, e.cyc, e.fl, e.idx);
      end
   endtask

   always @(negedge clk)
      if (reset) observe(0, {dready_a, w_a, wtag_a, setd_a, mstb_a, mrw_a, mas_a, wsel_a, rsel_a}, int'(widx_a));
      else prev_mstb[0] = 1'b0;
   always @(negedge clk)
      if (reset) observe(1, {dready_b, w_b, wtag_b, setd_b, mstb_b, mrw_b, mas_b, wsel_b, rsel_b}, int'(widx_b));
      else prev_mstb[1] = 1'b0;
   always @(negedge clk)
      if (reset) observe(2, {dready_c, w_c, wtag_c, setd_c, mstb_c, mrw_c, mas_c, wsel_c, rsel_c}, int'(widx_c));
      else prev_mstb[2] = 1'b0;

   function automatic int qsize(input int k);
      case (k)
         0: return q_a.size();
         1: return q_b.size();
         default: return q_c.size();
      endcase
   endfunction

   // Issue one request, hold Strobe until relative cycle `hold`, wait until `wait_c`.
   task automatic req(input int k, input logic drw, input logic m, input logic v, input logic d,
                      input int hold, input int wait_c, input string nm);
      @(negedge clk);
      case (k)
         0: begin strobe_a = 1'b1; drw_a = drw; m_a = m; v_a = v; d_a = d; end
         1: begin strobe_b = 1'b1; drw_b = drw; m_b = m; v_b = v; d_b = d; end
         default: begin strobe_c = 1'b1; drw_c = drw; m_c = m; v_c = v; d_c = d; end
      endcase
      t0[k] = cyc;
      while (cyc - t0[k] < hold) @(negedge clk);
      case (k)
         0: strobe_a = 1'b0;
         1: strobe_b = 1'b0;
         default: strobe_c = 1'b0;
      endcase
      while (cyc - t0[k] < wait_c) @(negedge clk);
      chk({nm, "_pending"}, qsize(k), 0);
   endtask

   function automatic int outs_a();
      return int'({dready_a, w_a, wtag_a, setd_a, mstb_a, mrw_a, mas_a, wsel_a, rsel_a, widx_a});
   endfunction

   initial begin
      checks = 0;
      passes = 0;
      for (int k = 0; k < 3; k++) begin t0[k] = 0; prev_mstb[k] = 1'b0; end
      reset = 1'b0;
      {strobe_a, drw_a, m_a, v_a, d_a} = '0;
      {strobe_b, drw_b, m_b, v_b, d_b} = '0;
      {strobe_c, drw_c, m_c, v_c, d_c} = '0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("reset_outs_a", outs_a(), 0);
      chk("reset_outs_b", int'({dready_b, w_b, wtag_b, setd_b, mstb_b, mrw_b, mas_b, wsel_b, rsel_b, widx_b}), 0);
      chk("reset_outs_c", int'({dready_c, w_c, wtag_c, setd_c, mstb_c, mrw_c, mas_c, wsel_c, rsel_c, widx_c}), 0);

      // Read hit.
      push_a(2, F_DREADY, 0);
      req(0, 1'b0, 1'b1, 1'b1, 1'b0, 1, 6, "read_hit");

      // Write hit.
      push_a(2, F_W | F_SETD, 0);
      push_a(3, F_DREADY, 0);
      req(0, 1'b1, 1'b1, 1'b1, 1'b1, 1, 7, "write_hit");

      // Clean read miss.
      push_fill_a(2, 4);
      push_a(26, F_DREADY, 0);
      req(0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 30, "clean_read_miss");

      // Dirty read miss.
      push_wb_a(2);
      push_fill_a(22, 4);
      push_a(46, F_DREADY, 0);
      req(0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 50, "dirty_read_miss");

      // Allocating write miss to an invalid line (dirty bit must be ignored).
      push_fill_a(2, 4);
      push_a(26, F_W | F_SETD, 0);
      push_a(27, F_DREADY, 0);
      req(0, 1'b1, 1'b1, 1'b0, 1'b1, 1, 31, "alloc_write_miss_clean");

      // Allocating write miss with a dirty victim.
      push_wb_a(2);
      push_fill_a(22, 4);
      push_a(46, F_W | F_SETD, 0);
      push_a(47, F_DREADY, 0);
      req(0, 1'b1, 1'b0, 1'b1, 1'b1, 1, 51, "alloc_write_miss_dirty");

      // Strobe held through DONE is re-accepted as a second request.
      push_a(2, F_DREADY, 0);
      push_a(5, F_DREADY, 0);
      req(0, 1'b0, 1'b1, 1'b1, 1'b0, 6, 10, "held_strobe");

      // Write-around miss.
      q_b.push_back(mk(2, F_MSTB | F_MRW | F_RSEL, 0));
      q_b.push_back(mk(7, F_DREADY, 0));
      req(1, 1'b1, 1'b0, 1'b1, 1'b1, 1, 11, "write_around_miss");

      // Write hit with write-around configuration.
      q_b.push_back(mk(2, F_W | F_SETD, 0));
      q_b.push_back(mk(3, F_DREADY, 0));
      req(1, 1'b1, 1'b1, 1'b1, 1'b0, 1, 7, "write_around_hit");

      // Single-word line, one wait state, clean read miss.
      q_c.push_back(mk(2, F_MSTB, 0));
      q_c.push_back(mk(4, F_W | F_WSEL | F_WTAG, 0));
      q_c.push_back(mk(5, F_DREADY, 0));
      req(2, 1'b0, 1'b0, 1'b1, 1'b0, 1, 9, "small_read_miss");

      // Reset mid-refill: third word's FILL_WAIT.
      push_fill_a(2, 2);
      push_a(14, F_MSTB, 2);
      @(negedge clk);
      strobe_a = 1'b1; drw_a = 1'b0; m_a = 1'b0; v_a = 1'b1; d_a = 1'b0;
      t0[0] = cyc;
      @(negedge clk);
      strobe_a = 1'b0;
      while (cyc - t0[0] < 16) @(negedge clk);
      chk("pre_reset_wordidx", int'(widx_a), 2);
      reset = 1'b0;
      #1;
      chk("async_reset_outs", outs_a(), 0);
      chk("async_reset_pending", q_a.size(), 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      chk("post_reset_idle_outs", outs_a(), 0);

      chk("final_pending_a", q_a.size(), 0);
      chk("final_pending_b", q_b.size(), 0);
      chk("final_pending_c", q_c.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
